dpram_sclk_be: RTL

DPRAM_SCLK_BE -- requirements
Module: dpram_sclk_be

---
 rtl/dpram_pkg.sv | 23 ++
 rtl/dpram_sclk_be.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_pkg
//  Description : Shared constants and state encodings for the single-clock
//                byte-enable dual-port RAM (dpram_sclk_be).
//                - RDW_READ_FIRST / RDW_WRITE_FIRST : read-during-write modes
//                - clr_state_e                      : clear sequencer states
//  Revision    : 1.0  initial release
// ============================================================================
package dpram_pkg;

  // Same-address read-during-write behaviour.
  localparam int RDW_READ_FIRST  = 0;  // read returns the pre-write word
  localparam int RDW_WRITE_FIRST = 1;  // read returns the byte-merged new word

  // Clear sequencer: CLEAR zero-fills the array, RUN serves requests.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/dpram_sclk_be.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_sclk_be
//  Description : Single-clock simple dual-port RAM (one write port, one read
//                port) with per-byte write enables, selectable read latency
//                (1 or 2), selectable same-address read-during-write mode and
//                an optional zero-fill sequence after reset.
//  Ports       :
//    clk        in   single clock, all logic on posedge
//    rst_n      in   asynchronous active-low reset
//    re         in   read request
//    raddr      in   read address   [ADDR_WIDTH]
//    we         in   write request
//    waddr      in   write address  [ADDR_WIDTH]
//    wbe        in   byte enables   [DATA_WIDTH/BYTE_WIDTH]
//    din        in   write data     [DATA_WIDTH]
//    dout       out  read data      [DATA_WIDTH], holds between results
//    dout_valid out  one-cycle pulse per completed read
//    init_busy  out  clear sequence running; requests are ignored
//  Revision    : 1.0  initial release
// ============================================================================
module dpram_sclk_be
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid,
  output logic                             init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

  localparam clr_state_e          C_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_WIDTH:0] C_LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] C_CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_err_byte_width
      $error("dpram_sclk_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_err_rd_latency
      $error("dpram_sclk_be: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  clr_state_e            r_state;
  clr_state_e            w_state_nxt;
  // One bit wider than the address so the count can reach DEPTH without
  // aliasing back onto address 0.
  logic [ADDR_WIDTH:0]   r_clr_cnt;
  logic [ADDR_WIDTH:0]   w_clr_cnt_nxt;
  logic                  w_clr_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= C_RST_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + C_CNT_ONE;
        if (r_clr_cnt == C_LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        // ST_RUN: idle until the next reset
      end
    endcase
  end

  assign init_busy = (r_state == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_wr_acc = we & ~init_busy;
  assign w_rd_acc = re & ~init_busy;

  // --------------------------------------------------------------------------
  // Memory write port: the clear sequencer owns the port while it runs.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [NB-1:0]         w_mem_be;
  logic [DATA_WIDTH-1:0] w_mem_data;

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = waddr;
    w_mem_be   = wbe;
    w_mem_data = din;
    if (w_clr_we) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_cnt[ADDR_WIDTH-1:0];
      w_mem_be   = '1;
      w_mem_data = '0;
    end else if (w_wr_acc) begin
      w_mem_we   = 1'b1;
    end
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read word selection. The array read is sampled on the same edge as the
  // write, so it naturally returns the old word; write-first overlays the
  // enabled bytes of the incoming data on a same-address collision.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_rd_word;

  always_comb begin
    w_rd_word = r_mem[raddr];
    if ((RDW_MODE == RDW_WRITE_FIRST) && w_wr_acc && (waddr == raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_s1_valid;
      logic [DATA_WIDTH-1:0] r_s1_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_valid   <= 1'b0;
          r_s1_data    <= '0;
          r_dout_valid <= 1'b0;
          r_dout       <= '0;
        end else begin
          r_s1_valid   <= w_rd_acc;
          if (w_rd_acc) begin
            r_s1_data <= w_rd_word;
          end
          // Output register only loads when a result completes so dout holds.
          r_dout_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_dout <= r_s1_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout_valid <= 1'b0;
          r_dout       <= '0;
        end else begin
          r_dout_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_dout <= w_rd_word;
          end
        end
      end
    end
  endgenerate

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule : dpram_sclk_be
`default_nettype wire
